// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
// State codes are plain localparams so older tools and netlists can read them.
package div_pkg;

  localparam int DIV_W = 16;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Step counter width for a given operand width (one step per quotient bit).
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_divider16_div_step.sv
// One restoring-division step: shift {R,Q} left, trial-subtract the divisor,
// keep the difference when it is non-negative, otherwise restore.
// The subtraction is an add of the inverted divisor with carry-in 1, the same
// form the shared adder/subtractor uses.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic             fits;

  // Shift in the next dividend bit, subtract, and choose keep or restore.
  always_comb begin
    shifted = {r, q[WIDTH-1]};
    trial   = shifted + ~{2'b00, divisor} + {{(WIDTH+1){1'b0}}, 1'b1};
    // R stays below the divisor, so the shifted value never reaches the
    // top bit and the difference sign is a clean "fits" flag.
    fits    = ~trial[WIDTH+1];
    r_next  = fits ? trial[WIDTH:0] : shifted[WIDTH:0];
    q_next  = {q[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/seq_divider16.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Optional build macro DIV_SIGNED_EN adds a signed_op input for two's
// complement division (magnitudes divided, signs fixed up on the way out).
//
// state | meaning
// IDLE  | waiting for start; results held
// RUN   | one shift/subtract step per clock, WIDTH steps
// DONE  | publish results (sign fix-up), pulse done on the exit edge
module seq_divider16
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             validity
);

  localparam int                CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvsr;
  logic             dz;
  logic             ovf;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] mag_dvd;
  logic [WIDTH-1:0] mag_dvs;
  logic             neg_q_in;
  logic             neg_r_in;
  logic             ovf_in;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_r;
  logic             accept;

  // Busy covers the done cycle too, so a start coincident with done is dropped.
  assign busy   = (state != IDLE) || done;
  assign accept = start && !busy;

`ifdef DIV_SIGNED_EN
  // Convert operands to magnitudes and remember the result signs.
  always_comb begin
    neg_r_in = signed_op & dividend[WIDTH-1];
    neg_q_in = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
    mag_dvd  = neg_r_in ? (~dividend + 1'b1) : dividend;
    mag_dvs  = (signed_op & divisor[WIDTH-1]) ? (~divisor + 1'b1) : divisor;
    ovf_in   = signed_op && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
               && (divisor == {WIDTH{1'b1}});
  end
`else
  assign neg_r_in = 1'b0;
  assign neg_q_in = 1'b0;
  assign mag_dvd  = dividend;
  assign mag_dvs  = divisor;
  assign ovf_in   = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .r       (r),
    .q       (q),
    .divisor (dvsr),
    .r_next  (r_next),
    .q_next  (q_next)
  );

  // Final result values: sign fix-up, or the divide-by-zero convention where
  // q still holds the raw dividend.
  always_comb begin
    res_q = neg_q ? (~q + 1'b1) : q;
    res_r = neg_r ? (~r[WIDTH-1:0] + 1'b1) : r[WIDTH-1:0];
    if (dz) begin
      res_q = {WIDTH{1'b1}};
      res_r = q;
    end
  end

  // FSM and step counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            count <= '0;
            state <= (divisor == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (count == LAST) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Working registers: operand capture on accept, one step per RUN cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r     <= '0;
      q     <= '0;
      dvsr  <= '0;
      dz    <= 1'b0;
      ovf   <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && accept) begin
      r     <= '0;
      q     <= (divisor == '0) ? dividend : mag_dvd;
      dvsr  <= mag_dvs;
      dz    <= (divisor == '0);
      ovf   <= ovf_in;
      neg_q <= neg_q_in;
      neg_r <= neg_r_in;
    end else if (state == RUN) begin
      r <= r_next;
      q <= q_next;
    end
  end

  // Result registers and done pulse, updated only when leaving DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      validity    <= 1'b1;
    end else begin
      done <= 1'b0;
      if (state == DONE) begin
        done        <= 1'b1;
        quotient    <= res_q;
        remainder   <= res_r;
        div_by_zero <= dz;
        validity    <= ~(dz | ovf);
      end
    end
  end

endmodule

// File: tb/tb_seq_divider16.sv
// Self-checking bench for seq_divider16: directed cases, busy/done protocol,
// mid-run reset and randomized operands against an arithmetic reference.
module tb_seq_divider16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
`ifdef DIV_SIGNED_EN
  logic        signed_op;
`endif
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        validity;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_divider16 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef DIV_SIGNED_EN
    .signed_op   (signed_op),
`endif
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .validity    (validity)
  );

  // Reference: plain integer division with the divide-by-zero convention.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic s,
                       output logic [15:0] eq, output logic [15:0] er,
                       output logic edz, output logic ev, output int elat);
    int sa, sb;
    edz  = (b == 16'd0);
    elat = edz ? 1 : 17;
    ev   = !edz;
    if (edz) begin
      eq = 16'hFFFF;
      er = a;
    end else if (s) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      eq = 16'(sa / sb);
      er = 16'(sa % sb);
      if (sa == -32768 && sb == -1) ev = 1'b0;
    end else begin
      eq = a / b;
      er = a % b;
    end
  endtask

  // Launch one operation and count edges from the accepting edge to done.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                       output int lat);
    @(negedge clk);
    dividend = a;
    divisor  = b;
`ifdef DIV_SIGNED_EN
    signed_op = s;
`endif
    start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor  = '0;
`ifdef DIV_SIGNED_EN
    signed_op = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero, validity} !== {2'b00, 32'h0, 2'b01}) begin
      failures++;
      $display("FAIL reset busy=%b done=%b q=%h r=%h dz=%b v=%b expected 0 0 0000 0000 0 1",
               busy, done, quotient, remainder, div_by_zero, validity);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [15:0] ta [5] = '{16'd100, 16'hFFFF, 16'h0003, 16'd5, 16'd0};
    logic [15:0] tb [5] = '{16'd7,   16'h0001, 16'h0010, 16'd0, 16'd9};
    logic [15:0] eq, er;
    logic edz, ev;
    int elat, lat;
    for (int i = 0; i < 5; i++) begin
      model(ta[i], tb[i], 1'b0, eq, er, edz, ev, elat);
      do_op(ta[i], tb[i], 1'b0, lat);
      checks++;
      if (lat != elat || {quotient, remainder, div_by_zero, validity} !== {eq, er, edz, ev}) begin
        failures++;
        $display("FAIL directed_%0d lat=%0d q=%h r=%h dz=%b v=%b expected lat=%0d q=%h r=%h dz=%b v=%b",
                 i, lat, quotient, remainder, div_by_zero, validity, elat, eq, er, edz, ev);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL done_pulse_%0d done=%b busy=%b expected 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_ignore_busy();
    int lat;
    @(negedge clk);
    dividend = 16'd100;
    divisor  = 16'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = (n == 5);
      if (n == 5) begin
        dividend = 16'd9;
        divisor  = 16'd3;
      end
      @(posedge clk);
      #1;
      if (n == 5) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL busy_mid_run busy=%b expected 1", busy);
        end
      end
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (lat != 17 || quotient !== 16'd14 || remainder !== 16'd2) begin
      failures++;
      $display("FAIL ignore_busy lat=%0d q=%0d r=%0d expected lat=17 q=14 r=2", lat, quotient, remainder);
    end
    @(posedge clk);
    #1;
    do_op(16'd9, 16'd3, 1'b0, lat);
    checks++;
    if (lat != 17 || quotient !== 16'd3 || remainder !== 16'd0) begin
      failures++;
      $display("FAIL after_ignore lat=%0d q=%0d r=%0d expected lat=17 q=3 r=0", lat, quotient, remainder);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    bit seen;
    do_op(16'd1000, 16'd33, 1'b0, lat);
    // Start raised during the done cycle: dropped at that edge, accepted next.
    @(negedge clk);
    dividend = 16'd50000;
    divisor  = 16'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || quotient !== 16'd30 || remainder !== 16'd10) begin
      failures++;
      $display("FAIL start_in_done busy=%b q=%0d r=%0d expected busy=0 q=30 r=10", busy, quotient, remainder);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = 16'd1;
    divisor  = 16'd1;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat != 17 || quotient !== 16'd7142 || remainder !== 16'd6) begin
      failures++;
      $display("FAIL back_to_back lat=%0d q=%0d r=%0d expected lat=17 q=7142 r=6", lat, quotient, remainder);
    end
    seen = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    @(negedge clk);
    dividend = 16'd100;
    divisor  = 16'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero, validity} !== {2'b00, 32'h0, 2'b01}) begin
      failures++;
      $display("FAIL reset_mid busy=%b done=%b q=%h r=%h dz=%b v=%b expected 0 0 0000 0000 0 1",
               busy, done, quotient, remainder, div_by_zero, validity);
    end
    rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) seen = 1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL aborted_run activity=1 expected 0");
    end
    do_op(16'd20, 16'd6, 1'b0, lat);
    checks++;
    if (lat != 17 || quotient !== 16'd3 || remainder !== 16'd2) begin
      failures++;
      $display("FAIL after_reset lat=%0d q=%0d r=%0d expected lat=17 q=3 r=2", lat, quotient, remainder);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random(input bit s);
    logic [15:0] a, b, eq, er;
    logic edz, ev;
    int elat, lat;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 16'($urandom_range(0, 15));
        1:       b = 16'hFFFF - 16'($urandom_range(0, 3));
        default: b = 16'($urandom);
      endcase
      if (i == 0) b = 16'd0;
      model(a, b, s, eq, er, edz, ev, elat);
      do_op(a, b, s, lat);
      checks++;
      if (lat != elat || {quotient, remainder, div_by_zero, validity} !== {eq, er, edz, ev}) begin
        failures++;
        $display("FAIL random_%0d a=%h b=%h lat=%0d q=%h r=%h dz=%b v=%b expected lat=%0d q=%h r=%h dz=%b v=%b",
                 i, a, b, lat, quotient, remainder, div_by_zero, validity, elat, eq, er, edz, ev);
      end
      @(posedge clk);
      #1;
    end
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    logic [15:0] ta [3] = '{16'hFFF9, 16'h8000, 16'd7};
    logic [15:0] tb [3] = '{16'd2,    16'hFFFF, 16'hFFFE};
    logic [15:0] eq, er;
    logic edz, ev;
    int elat, lat;
    for (int i = 0; i < 3; i++) begin
      model(ta[i], tb[i], 1'b1, eq, er, edz, ev, elat);
      do_op(ta[i], tb[i], 1'b1, lat);
      checks++;
      if (lat != elat || {quotient, remainder, div_by_zero, validity} !== {eq, er, edz, ev}) begin
        failures++;
        $display("FAIL signed_%0d lat=%0d q=%h r=%h dz=%b v=%b expected lat=%0d q=%h r=%h dz=%b v=%b",
                 i, lat, quotient, remainder, div_by_zero, validity, elat, eq, er, edz, ev);
      end
      @(posedge clk);
      #1;
    end
    test_random(1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_random(1'b0);
`ifdef DIV_SIGNED_EN
    test_signed();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
